// File: rtl/uop_buf_ctrl_pkg.sv
// Shared sizing constants and the uop entry layout for the uop buffer controller.
package uop_buf_ctrl_pkg;

    localparam int UOP_BUF_SIZE           = 128;
    localparam int MAX_PREDICT_DEPTH      = 3;
    localparam int MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH);
    localparam int UOP_BUF_ADDR_W         = $clog2(UOP_BUF_SIZE);
    localparam int UOP_BUF_CNT_W          = UOP_BUF_ADDR_W + 1;
    localparam int UOP_BUF_WIDTH          = 64 + 2 * MAX_PREDICT_DEPTH_BITS;

    typedef struct packed {
        logic [31:0]                       instr_1;
        logic [31:0]                       instr_2;
        logic [MAX_PREDICT_DEPTH_BITS-1:0] tag_1;
        logic [MAX_PREDICT_DEPTH_BITS-1:0] tag_2;
    } uop_t;

endpackage

// File: rtl/uop_buf_ctrl_rr_arb2.sv
// Two-way round-robin arbiter for the single RAM port: fetch wins while rr=0,
// fill wins while rr=1, and a contested grant hands priority to the loser.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_req_fetch,
    input  logic i_req_fill,
    output logic o_gnt_fetch,
    output logic o_gnt_fill
);

    logic r_rr;

    // Same-cycle grant; a lone requester always wins.
    always_comb begin
        o_gnt_fetch = i_req_fetch && (!i_req_fill || !r_rr);
        o_gnt_fill  = i_req_fill  && (!i_req_fetch || r_rr);
    end

    // Priority flips only when both sides competed.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_rr <= 1'b0;
        end else if (i_req_fetch && i_req_fill) begin
            r_rr <= ~r_rr;
        end
    end

endmodule

// File: rtl/uop_buf_ctrl.sv
// Uop buffer controller: circular head/tail pointers over an external
// single-port RAM, fill/fetch arbitration, and per-tag branch checkpoints
// that let a mispredict squash roll the tail back to just after the branch.
module uop_buf_ctrl #(
    parameter int UOP_BUF_SIZE           = uop_buf_ctrl_pkg::UOP_BUF_SIZE,
    parameter int MAX_PREDICT_DEPTH      = uop_buf_ctrl_pkg::MAX_PREDICT_DEPTH,
    parameter int MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH),
    parameter int UOP_BUF_WIDTH          = 64 + 2 * MAX_PREDICT_DEPTH_BITS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              fill_req,
    input  logic [UOP_BUF_WIDTH-1:0]          fill_data,
    input  logic                              fill_ckpt,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] fill_tag,
    output logic                              fill_ack,
    input  logic                              fetch_req,
    output logic                              fetch_ack,
    output logic [UOP_BUF_WIDTH-1:0]          fetch_data,
    output logic                              fetch_data_valid,
    input  logic                              squash_valid,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] squash_tag,
    output logic                              ram_en,
    output logic                              ram_we,
    output logic [$clog2(UOP_BUF_SIZE)-1:0]   ram_addr,
    output logic [UOP_BUF_WIDTH-1:0]          ram_wdata,
    input  logic [UOP_BUF_WIDTH-1:0]          ram_rdata,
    output logic [$clog2(UOP_BUF_SIZE):0]     count,
    output logic                              full,
    output logic                              empty
);

    import uop_buf_ctrl_pkg::*;

    localparam int ADDR_W = $clog2(UOP_BUF_SIZE);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(UOP_BUF_SIZE);

    logic [ADDR_W-1:0]            r_head;
    logic [ADDR_W-1:0]            r_tail;
    logic [CNT_W-1:0]             r_count;
    logic [ADDR_W-1:0]            r_ckpt_ptr [MAX_PREDICT_DEPTH];
    logic [MAX_PREDICT_DEPTH-1:0] r_ckpt_valid;
    logic                         r_fetch_pend;

    logic              w_block;
    logic              w_gnt_fill;
    logic              w_gnt_fetch;
    logic              w_sq_hit;
    logic [ADDR_W-1:0] w_sq_ptr;
    logic [CNT_W-1:0]  w_keep;

    assign full             = (r_count == FULL_CNT);
    assign empty            = (r_count == '0);
    assign count            = r_count;
    assign fetch_data_valid = r_fetch_pend;
    assign fetch_data       = ram_rdata;

    // Reset, clear and squash own the cycle; the RAM port stays idle.
    assign w_block = reset || clear || squash_valid;

    rr_arb2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (clear),
        .i_req_fetch (fetch_req && !empty && !w_block),
        .i_req_fill  (fill_req && !full && !w_block),
        .o_gnt_fetch (w_gnt_fetch),
        .o_gnt_fill  (w_gnt_fill)
    );

    // Drive the RAM port from whichever side won this cycle.
    always_comb begin
        fill_ack  = w_gnt_fill;
        fetch_ack = w_gnt_fetch;
        ram_en    = w_gnt_fill || w_gnt_fetch;
        ram_we    = w_gnt_fill;
        ram_addr  = w_gnt_fill ? r_tail : (w_gnt_fetch ? r_head : '0);
        ram_wdata = w_gnt_fill ? fill_data : '0;
    end

    // Look up the squashed tag; a zero distance with a full buffer means every entry survives.
    always_comb begin
        w_sq_hit = 1'b0;
        w_sq_ptr = '0;
        for (int t = 0; t < MAX_PREDICT_DEPTH; t++) begin
            if (squash_tag == MAX_PREDICT_DEPTH_BITS'(t)) begin
                w_sq_hit = r_ckpt_valid[t];
                w_sq_ptr = r_ckpt_ptr[t];
            end
        end
        w_keep = {1'b0, w_sq_ptr - r_head};
        if (w_keep == '0 && full) begin
            w_keep = FULL_CNT;
        end
    end

    // Pointer, occupancy and checkpoint bookkeeping in priority order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_ckpt_valid <= '0;
            r_fetch_pend <= 1'b0;
            for (int t = 0; t < MAX_PREDICT_DEPTH; t++) begin
                r_ckpt_ptr[t] <= '0;
            end
        end else begin
            r_fetch_pend <= w_gnt_fetch;
            if (clear) begin
                r_head       <= '0;
                r_tail       <= '0;
                r_count      <= '0;
                r_ckpt_valid <= '0;
            end else if (squash_valid) begin
                r_ckpt_valid <= '0;
                if (w_sq_hit) begin
                    r_tail  <= w_sq_ptr;
                    r_count <= w_keep;
                end else begin
                    r_head  <= '0;
                    r_tail  <= '0;
                    r_count <= '0;
                end
            end else if (w_gnt_fill) begin
                r_tail  <= r_tail + ADDR_W'(1);
                r_count <= r_count + CNT_W'(1);
                for (int t = 0; t < MAX_PREDICT_DEPTH; t++) begin
                    if (fill_ckpt && fill_tag == MAX_PREDICT_DEPTH_BITS'(t)) begin
                        r_ckpt_ptr[t]   <= r_tail + ADDR_W'(1);
                        r_ckpt_valid[t] <= 1'b1;
                    end
                end
            end else if (w_gnt_fetch) begin
                r_head  <= r_head + ADDR_W'(1);
                r_count <= r_count - CNT_W'(1);
                // Once the branch entry itself leaves, its checkpoint has nothing left to protect.
                for (int t = 0; t < MAX_PREDICT_DEPTH; t++) begin
                    if (r_head == r_ckpt_ptr[t] - ADDR_W'(1)) begin
                        r_ckpt_valid[t] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uop_buf_ctrl.sv
// Self-checking bench for uop_buf_ctrl: directed scenarios plus a randomized
// run, all checked against a sequence-number/queue model of the buffer.
module tb_uop_buf_ctrl;
    import uop_buf_ctrl_pkg::*;

    localparam int W  = UOP_BUF_WIDTH;
    localparam int AW = UOP_BUF_ADDR_W;
    localparam int CW = UOP_BUF_CNT_W;
    localparam int TW = MAX_PREDICT_DEPTH_BITS;
    localparam int N  = UOP_BUF_SIZE;
    localparam int D  = MAX_PREDICT_DEPTH;

    logic          clk = 1'b0;
    logic          reset = 1'b1, clear = 1'b0, fill_req = 1'b0, fill_ckpt = 1'b0;
    logic          fetch_req = 1'b0, squash_valid = 1'b0;
    logic [W-1:0]  fill_data = '0;
    logic [TW-1:0] fill_tag = '0, squash_tag = '0;
    logic          fill_ack, fetch_ack, fetch_data_valid, ram_en, ram_we, full, empty;
    logic [W-1:0]  fetch_data, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [CW-1:0] count;
    logic [W-1:0]  mem [N];

    int n_cmp = 0, n_bad = 0;

    uop_buf_ctrl dut (
        .clk(clk), .reset(reset), .clear(clear),
        .fill_req(fill_req), .fill_data(fill_data), .fill_ckpt(fill_ckpt), .fill_tag(fill_tag),
        .fill_ack(fill_ack), .fetch_req(fetch_req), .fetch_ack(fetch_ack),
        .fetch_data(fetch_data), .fetch_data_valid(fetch_data_valid),
        .squash_valid(squash_valid), .squash_tag(squash_tag),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Reference model: queue of live entries, absolute read/write sequence numbers.
    logic [W-1:0] m_q [$];
    int           m_rd = 0, m_wr = 0;
    bit           m_rr = 1'b0;
    int           m_ck_seq [D];
    bit           m_ck_v [D];
    bit           m_pend = 1'b0;
    logic [W-1:0] m_pend_data = '0;

    // Observed and expected values for the most recent cycle.
    logic          o_fill_ack, o_fetch_ack, o_ram_en, o_ram_we, o_full, o_empty, o_fdv;
    logic [AW-1:0] o_ram_addr;
    logic [W-1:0]  o_ram_wdata, o_fdata;
    logic [CW-1:0] o_count;
    bit            e_fill_ack, e_fetch_ack, e_full, e_empty, e_fdv;
    logic [AW-1:0] e_addr;
    logic [W-1:0]  e_fdata;
    int            e_count;

    function automatic logic [W-1:0] rnd_uop();
        uop_t u;
        u.instr_1 = $urandom;
        u.instr_2 = $urandom;
        u.tag_1   = TW'($urandom_range(0, D - 1));
        u.tag_2   = TW'($urandom_range(0, D - 1));
        return u;
    endfunction

    task automatic model_cycle(input bit rst, input bit clr, input bit fr, input logic [W-1:0] fd,
                               input bit fc, input int ft, input bit xr, input bit sq, input int st);
        bit fe, xe, gf, gx;
        int keep;
        e_count = m_q.size();
        e_full  = (m_q.size() == N);
        e_empty = (m_q.size() == 0);
        e_fdv   = m_pend;
        e_fdata = m_pend_data;
        fe = fr && (m_q.size() < N);
        xe = xr && (m_q.size() > 0);
        gf = 1'b0;
        gx = 1'b0;
        if (!(rst || clr || sq)) begin
            if (fe && xe) begin
                gf   = m_rr;
                gx   = !m_rr;
                m_rr = !m_rr;
            end else begin
                gf = fe;
                gx = xe;
            end
        end
        e_fill_ack  = gf;
        e_fetch_ack = gx;
        e_addr      = gf ? AW'(m_wr % N) : (gx ? AW'(m_rd % N) : '0);
        m_pend      = gx;
        if (gx) m_pend_data = m_q[0];
        if (rst || clr) begin
            m_q.delete();
            m_rd = 0; m_wr = 0; m_rr = 1'b0;
            for (int t = 0; t < D; t++) m_ck_v[t] = 1'b0;
        end else if (sq) begin
            if (st < D && m_ck_v[st]) begin
                keep = m_ck_seq[st] - m_rd;
                while (m_q.size() > keep) void'(m_q.pop_back());
                m_wr = m_ck_seq[st];
            end else begin
                m_q.delete();
                m_rd = 0; m_wr = 0;
            end
            for (int t = 0; t < D; t++) m_ck_v[t] = 1'b0;
        end else if (gf) begin
            m_q.push_back(fd);
            m_wr++;
            if (fc && ft < D) begin
                m_ck_seq[ft] = m_wr;
                m_ck_v[ft]   = 1'b1;
            end
        end else if (gx) begin
            void'(m_q.pop_front());
            m_rd++;
            for (int t = 0; t < D; t++)
                if (m_ck_v[t] && m_ck_seq[t] == m_rd) m_ck_v[t] = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, sample the DUT mid-cycle, advance the model.
    task automatic step(input bit rst, input bit clr, input bit fr, input logic [W-1:0] fd,
                        input bit fc, input int ft, input bit xr, input bit sq, input int st);
        @(negedge clk);
        reset = rst; clear = clr; fill_req = fr; fill_data = fd; fill_ckpt = fc;
        fill_tag = TW'(ft); fetch_req = xr; squash_valid = sq; squash_tag = TW'(st);
        #2;
        o_fill_ack = fill_ack; o_fetch_ack = fetch_ack; o_ram_en = ram_en; o_ram_we = ram_we;
        o_ram_addr = ram_addr; o_ram_wdata = ram_wdata; o_count = count; o_full = full;
        o_empty = empty; o_fdv = fetch_data_valid; o_fdata = fetch_data;
        model_cycle(rst, clr, fr, fd, fc, ft, xr, sq, st);
    endtask

    task automatic idle();          step(0, 0, 0, '0, 0, 0, 0, 0, 0); endtask
    task automatic do_clear();      step(0, 1, 0, '0, 0, 0, 0, 0, 0); endtask
    task automatic do_fill(input logic [W-1:0] d, input bit fc, input int ft);
        step(0, 0, 1, d, fc, ft, 0, 0, 0);
    endtask
    task automatic do_fetch();      step(0, 0, 0, '0, 0, 0, 1, 0, 0); endtask

    task automatic test_reset();
        step(1, 0, 1, rnd_uop(), 0, 0, 1, 0, 0);
        n_cmp++; if (o_fill_ack !== 1'b0) begin n_bad++; $display("FAIL reset_fill_ack: got %0b want 0", o_fill_ack); end
        n_cmp++; if (o_ram_en !== 1'b0) begin n_bad++; $display("FAIL reset_ram_en: got %0b want 0", o_ram_en); end
        idle();
        n_cmp++; if (o_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", o_count); end
        n_cmp++; if (o_full !== 1'b0 || o_empty !== 1'b1) begin n_bad++; $display("FAIL reset_flags: got full=%0b empty=%0b want 0/1", o_full, o_empty); end
        n_cmp++; if (o_fdv !== 1'b0) begin n_bad++; $display("FAIL reset_fdv: got %0b want 0", o_fdv); end
    endtask

    task automatic test_fill3();
        logic [W-1:0] d;
        for (int i = 0; i < 3; i++) begin
            d = rnd_uop();
            do_fill(d, 0, 0);
            n_cmp++; if (o_fill_ack !== 1'b1 || o_ram_we !== 1'b1) begin n_bad++; $display("FAIL fill3_ack: got ack=%0b we=%0b want 1/1", o_fill_ack, o_ram_we); end
            n_cmp++; if (o_ram_addr !== AW'(i)) begin n_bad++; $display("FAIL fill3_addr: got %0d want %0d", o_ram_addr, i); end
            n_cmp++; if (o_ram_wdata !== d) begin n_bad++; $display("FAIL fill3_wdata: got %0h want %0h", o_ram_wdata, d); end
        end
        idle();
        n_cmp++; if (o_count !== CW'(3) || o_empty !== 1'b0) begin n_bad++; $display("FAIL fill3_count: got count=%0d empty=%0b want 3/0", o_count, o_empty); end
    endtask

    task automatic test_alternate();
        do_fill(rnd_uop(), 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, rnd_uop(), 0, 0, 1, 0, 0);
            n_cmp++; if (o_fetch_ack !== (i % 2 == 0) || o_fill_ack !== (i % 2 == 1)) begin n_bad++; $display("FAIL alt_grant%0d: got fetch=%0b fill=%0b want fetch=%0b", i, o_fetch_ack, o_fill_ack, (i % 2 == 0)); end
            n_cmp++; if (o_count < CW'(3) || o_count > CW'(4)) begin n_bad++; $display("FAIL alt_count%0d: got %0d want 3..4", i, o_count); end
            n_cmp++; if (o_fdv !== e_fdv) begin n_bad++; $display("FAIL alt_fdv%0d: got %0b want %0b", i, o_fdv, e_fdv); end
            if (e_fdv) begin
                n_cmp++; if (o_fdata !== e_fdata) begin n_bad++; $display("FAIL alt_data%0d: got %0h want %0h", i, o_fdata, e_fdata); end
            end
        end
    endtask

    task automatic test_full_wrap();
        do_clear();
        for (int i = 0; i < N; i++) do_fill(rnd_uop(), 0, 0);
        idle();
        n_cmp++; if (o_full !== 1'b1 || o_count !== CW'(N)) begin n_bad++; $display("FAIL full_flag: got full=%0b count=%0d want 1/%0d", o_full, o_count, N); end
        do_fill(rnd_uop(), 0, 0);
        n_cmp++; if (o_fill_ack !== 1'b0) begin n_bad++; $display("FAIL full_fill_ack: got %0b want 0", o_fill_ack); end
        do_fetch();
        n_cmp++; if (o_fetch_ack !== 1'b1 || o_ram_addr !== '0) begin n_bad++; $display("FAIL full_fetch: got ack=%0b addr=%0d want 1/0", o_fetch_ack, o_ram_addr); end
        do_fill(rnd_uop(), 0, 0);
        n_cmp++; if (o_fill_ack !== 1'b1 || o_ram_addr !== '0) begin n_bad++; $display("FAIL wrap_fill: got ack=%0b addr=%0d want 1/0", o_fill_ack, o_ram_addr); end
        n_cmp++; if (o_fdv !== 1'b1 || o_fdata !== e_fdata) begin n_bad++; $display("FAIL wrap_data: got v=%0b %0h want 1 %0h", o_fdv, o_fdata, e_fdata); end
    endtask

    task automatic test_squash();
        do_clear();
        do_fill(rnd_uop(), 0, 0);
        do_fill(rnd_uop(), 0, 0);
        do_fill(rnd_uop(), 1, 1);
        for (int i = 0; i < 3; i++) do_fill(rnd_uop(), 0, 0);
        step(0, 0, 1, rnd_uop(), 0, 0, 0, 1, 1);
        n_cmp++; if (o_ram_en !== 1'b0 || o_fill_ack !== 1'b0) begin n_bad++; $display("FAIL squash_block: got en=%0b ack=%0b want 0/0", o_ram_en, o_fill_ack); end
        idle();
        n_cmp++; if (o_count !== CW'(3)) begin n_bad++; $display("FAIL squash_count: got %0d want 3", o_count); end
        do_fill(rnd_uop(), 0, 0);
        n_cmp++; if (o_fill_ack !== 1'b1 || o_ram_addr !== AW'(3)) begin n_bad++; $display("FAIL squash_resume: got ack=%0b addr=%0d want 1/3", o_fill_ack, o_ram_addr); end
    endtask

    task automatic test_ckpt_consumed();
        do_clear();
        do_fill(rnd_uop(), 1, 0);
        do_fill(rnd_uop(), 0, 0);
        do_fill(rnd_uop(), 0, 0);
        do_fetch();
        n_cmp++; if (o_fetch_ack !== 1'b1 || o_ram_addr !== '0) begin n_bad++; $display("FAIL ckc_fetch: got ack=%0b addr=%0d want 1/0", o_fetch_ack, o_ram_addr); end
        step(0, 0, 0, '0, 0, 0, 0, 1, 0);
        idle();
        n_cmp++; if (o_count !== '0 || o_empty !== 1'b1) begin n_bad++; $display("FAIL ckc_flush: got count=%0d empty=%0b want 0/1", o_count, o_empty); end
        do_fill(rnd_uop(), 0, 0);
        n_cmp++; if (o_ram_addr !== '0) begin n_bad++; $display("FAIL ckc_addr: got %0d want 0", o_ram_addr); end
    endtask

    task automatic test_clear_reset();
        do_clear();
        for (int i = 0; i < 3; i++) do_fill(rnd_uop(), 0, 0);
        do_fetch();
        do_clear();
        n_cmp++; if (o_fdv !== 1'b1 || o_fdata !== e_fdata) begin n_bad++; $display("FAIL clr_return: got v=%0b %0h want 1 %0h", o_fdv, o_fdata, e_fdata); end
        idle();
        n_cmp++; if (o_fdv !== 1'b0 || o_count !== '0) begin n_bad++; $display("FAIL clr_state: got v=%0b count=%0d want 0/0", o_fdv, o_count); end
        do_fill(rnd_uop(), 1, 2);
        do_fill(rnd_uop(), 0, 0);
        step(0, 0, 1, rnd_uop(), 0, 0, 1, 0, 0);
        step(1, 0, 1, rnd_uop(), 0, 0, 1, 0, 0);
        n_cmp++; if (o_fill_ack !== 1'b0 || o_fetch_ack !== 1'b0 || o_ram_en !== 1'b0) begin n_bad++; $display("FAIL rst_mid_acks: got %0b%0b%0b want 000", o_fill_ack, o_fetch_ack, o_ram_en); end
        step(0, 0, 0, '0, 0, 0, 1, 0, 0);
        n_cmp++; if (o_count !== '0 || o_empty !== 1'b1 || o_full !== 1'b0) begin n_bad++; $display("FAIL rst_mid_state: got count=%0d empty=%0b full=%0b", o_count, o_empty, o_full); end
        n_cmp++; if (o_fdv !== 1'b0 || o_fetch_ack !== 1'b0) begin n_bad++; $display("FAIL rst_mid_fetch: got v=%0b ack=%0b want 0/0", o_fdv, o_fetch_ack); end
    endtask

    task automatic test_random();
        bit fr, xr, fc, sq, clr;
        int ph, pf, px;
        logic [W-1:0] d;
        do_clear();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            ph = (cyc / 150) % 3;
            pf = (ph == 0) ? 90 : (ph == 1) ? 20 : 70;
            px = (ph == 0) ? 20 : (ph == 1) ? 90 : 70;
            fr  = ($urandom_range(0, 99) < pf);
            xr  = ($urandom_range(0, 99) < px);
            fc  = ($urandom_range(0, 99) < 20);
            sq  = ($urandom_range(0, 59) == 0);
            clr = ($urandom_range(0, 399) == 0);
            d   = rnd_uop();
            step(0, clr, fr, d, fc, $urandom_range(0, D - 1), xr, sq, $urandom_range(0, D - 1));
            n_cmp++; if (o_fill_ack !== e_fill_ack || o_fetch_ack !== e_fetch_ack) begin n_bad++; $display("FAIL rnd_grant@%0d: got fill=%0b fetch=%0b want %0b/%0b", cyc, o_fill_ack, o_fetch_ack, e_fill_ack, e_fetch_ack); end
            n_cmp++; if (o_ram_en !== (e_fill_ack || e_fetch_ack) || o_ram_we !== e_fill_ack) begin n_bad++; $display("FAIL rnd_ram_ctl@%0d: got en=%0b we=%0b", cyc, o_ram_en, o_ram_we); end
            if (e_fill_ack || e_fetch_ack) begin
                n_cmp++; if (o_ram_addr !== e_addr) begin n_bad++; $display("FAIL rnd_addr@%0d: got %0d want %0d", cyc, o_ram_addr, e_addr); end
            end
            if (e_fill_ack) begin
                n_cmp++; if (o_ram_wdata !== d) begin n_bad++; $display("FAIL rnd_wdata@%0d: got %0h want %0h", cyc, o_ram_wdata, d); end
            end
            n_cmp++; if (o_count !== CW'(e_count) || o_full !== e_full || o_empty !== e_empty) begin n_bad++; $display("FAIL rnd_count@%0d: got %0d f=%0b e=%0b want %0d f=%0b e=%0b", cyc, o_count, o_full, o_empty, e_count, e_full, e_empty); end
            n_cmp++; if (o_fdv !== e_fdv) begin n_bad++; $display("FAIL rnd_fdv@%0d: got %0b want %0b", cyc, o_fdv, e_fdv); end
            if (e_fdv) begin
                n_cmp++; if (o_fdata !== e_fdata) begin n_bad++; $display("FAIL rnd_data@%0d: got %0h want %0h", cyc, o_fdata, e_fdata); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill3();
        test_alternate();
        test_full_wrap();
        test_squash();
        test_ckpt_consumed();
        test_clear_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
